// File: rtl/arb4_rr.sv
// arb4_rr: four-way round-robin arbiter with grant hold limit.
// All outputs are registered; the grant rotates on release or hold expiry.
module arb4_rr #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       forced
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    owner, owner_n;
    logic [CW-1:0] hold_cnt, cnt_n;
    logic          forced_n;
    logic [3:0]    gnt_n;
    logic          busy_n;
    logic [3:0]    own_oh;
    logic [3:0]    others;

    // First set bit of m, searching upward from p with wraparound.
    function automatic logic [1:0] pick(
        input logic [3:0] m,
        input logic [1:0] p
    );
        logic [1:0] r;
        logic [1:0] i;
        r = p;
        for (int k = 3; k >= 0; k--) begin
            i = p + 2'(k);
            if (m[i]) r = i;
        end
        return r;
    endfunction

    assign own_oh = 4'b0001 << owner;
    assign others = req & ~own_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            forced   <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= cnt_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            forced   <= forced_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        cnt_n    = hold_cnt;
        forced_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_n = pick(req, ptr);
                    ptr_n   = owner_n + 2'd1;
                    cnt_n   = CW'(1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[owner] && hold_cnt < CW'(MAX_HOLD)) begin
                    cnt_n = hold_cnt + CW'(1);
                end else if (!req[owner]) begin
                    if (|req) begin
                        owner_n = pick(req, ptr);
                        ptr_n   = owner_n + 2'd1;
                        cnt_n   = CW'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    // Hold expired: hand over, or re-grant a lone owner.
                    forced_n = 1'b1;
                    owner_n  = (|others) ? pick(others, ptr) : owner;
                    ptr_n    = owner_n + 2'd1;
                    cnt_n    = CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gnt_n  = 4'b0000;
        busy_n = 1'b0;
        if (state_n == GRANT) begin
            gnt_n  = 4'b0001 << owner_n;
            busy_n = 1'b1;
        end
    end

    assign gnt_id = owner;

endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: directed steps with a cycle model feeding a scoreboard queue.
// Expected outputs are queued per step and popped after the clock edge.
module tb_arb4_rr;

    localparam int MH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       forced;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       f;
    } exp_t;

    exp_t q[$];

    logic       m_act;
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    logic       m_forced;

    arb4_rr #(.MAX_HOLD(MH), .CW(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy),
        .forced(forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mpick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic mgrant(input int o);
        m_owner = o;
        m_ptr   = (o + 1) % 4;
        m_cnt   = 1;
        m_act   = 1'b1;
    endtask

    task automatic model(input logic r, input logic [3:0] rq);
        logic [3:0] oth;
        m_forced = 1'b0;
        if (r) begin
            m_act = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_act) begin
            if (rq != 0) mgrant(mpick(rq, m_ptr));
        end else if (rq[m_owner] && m_cnt < MH) begin
            m_cnt++;
        end else if (!rq[m_owner]) begin
            if (rq != 0) mgrant(mpick(rq, m_ptr));
            else begin m_act = 1'b0; m_cnt = 0; end
        end else begin
            m_forced = 1'b1;
            oth = rq;
            oth[m_owner] = 1'b0;
            mgrant(oth != 0 ? mpick(oth, m_ptr) : m_owner);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        exp_t e;
        rst = r;
        req = rq;
        model(r, rq);
        e.g  = m_act ? (4'b0001 << m_owner) : 4'b0000;
        e.id = 2'(m_owner);
        e.b  = m_act;
        e.f  = m_forced;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("gnt", gnt, e.g);
        chk("gnt_id", {2'b00, gnt_id}, {2'b00, e.id});
        chk("busy", {3'b000, busy}, {3'b000, e.b});
        chk("forced", {3'b000, forced}, {3'b000, e.f});
    endtask

    initial begin
        m_act = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_forced = 1'b0;
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);

        // reset with all requesting, then rotation
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        chk("rst_gnt", gnt, 4'b0000);
        step(1'b0, 4'b1111);
        chk("first_gnt", gnt, 4'b0001);
        for (int i = 0; i < 7; i++) step(1'b0, 4'b1111);
        chk("hold8_gnt", gnt, 4'b0001);
        step(1'b0, 4'b1111);
        chk("rot_gnt1", gnt, 4'b0010);
        chk("rot_forced", {3'b000, forced}, 4'b0001);
        for (int i = 0; i < 24; i++) step(1'b0, 4'b1111);
        chk("rot_wrap", gnt, 4'b0001);

        // release handover from owner 2 to pending 0
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0101);
        chk("own2", gnt, 4'b0100);
        step(1'b0, 4'b0001);
        chk("rel_gnt", gnt, 4'b0001);
        step(1'b0, 4'b0000);
        chk("rel_idle", {3'b000, busy}, 4'b0000);

        // lone requester expiry
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b1000);
            chk("lone_gnt", gnt, 4'b1000);
            chk("lone_forced", {3'b000, forced},
                (i == 8 || i == 16) ? 4'b0001 : 4'b0000);
        end

        // late arrival fairness
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b1011);
        step(1'b0, 4'b1001);
        chk("late_3", gnt, 4'b1000);
        step(1'b0, 4'b0001);
        chk("late_0", gnt, 4'b0001);

        // mid-grant reset
        step(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0100);
        step(1'b1, 4'b0101);
        chk("mid_rst", gnt, 4'b0000);
        step(1'b0, 4'b0101);
        chk("post_rst", gnt, 4'b0001);
        step(1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
